load_store_unit: RTL and testbench

- Memory-stage load/store unit sitting directly upstream of the word-organised data memory.
- Accepts one load/store request at a time from the pipeline via a valid/ready handshake.
- Checks the address against the data-memory window and checks alignment.
- Performs byte/halfword stores as read-modify-write on the word memory, extracts and extends byte/halfword loads, and returns the result or an error on a valid/ready response channel.

---
 rtl/load_store_unit_pkg.sv | 23 ++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access size
// codes and the bus widths used by the interface.
package lsu_pkg;

  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, RESP} lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned LSU_DW = 32;
  localparam int unsigned LSU_AW = 32;

  // Illegal size 11 is reported separately, so it falls through to 4 here.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [LSU_AW-1:0] req_addr;
  logic [LSU_DW-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [LSU_DW-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_wr_en;
  logic [LSU_AW-1:0] mem_addr;
  logic [LSU_DW-1:0] mem_din;
  logic [LSU_DW-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_wr_en, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_wr_en, mem_addr, mem_din
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane merge
// of store data into a memory word for read-modify-write stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = word[{offset[1], 4'b0000} +: 16];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        merged    = word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        merged    = word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: window/alignment check, sub-word loads with
// extension, and read-modify-write sub-word stores on a word-wide memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   MEM_BASE   = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0]   MEM_LIMIT  = 32'h0000_1068
)
(
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  lsu_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH:0]   req_end;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    req_end = {1'b0, bus.req_addr} + {{(ADDR_WIDTH-2){1'b0}}, size_bytes(bus.req_size)};
    req_err = (bus.req_size == 2'b11)
           || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
           || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
           || (bus.req_addr < MEM_BASE)
           || (req_end > {1'b0, MEM_LIMIT});
  end

  lsu_lane_align u_align (
    .word        (bus.mem_dout),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                  state_next = RESP;
          else if (bus.req_we && bus.req_size == SZ_WORD) state_next = WR;
          else                                          state_next = RD;
        end
      end
      RD:      state_next = RDATA;
      RDATA:   state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // wdata_q doubles as the write register: raw data for word stores, and the
  // merged word captured in RDATA for sub-word stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      size_q  <= bus.req_size;
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      err_q   <= req_err;
      wdata_q <= bus.req_wdata;
      rdata_q <= '0;
    end else if (state == RDATA) begin
      if (we_q) wdata_q <= merged;
      else      rdata_q <= load_data;
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      RD:   bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      WR: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_din   = wdata_q;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit against a word-array
// reference model of the data window.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_1068;
  localparam int unsigned NW    = 26;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_BASE   (BASE),
    .MEM_LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] ref_mem [NW];
  logic [31:0] mem     [NW];
  logic        preload;
  int unsigned wr_pulses;
  logic [31:0] last_wr_addr, last_wr_data;
  int unsigned passed = 0, failed = 0, total = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  // Word-organised memory with registered read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) mem[i] = ref_mem[i];
      wr_pulses = 0;
    end else if (bus.mem_wr_en) begin
      wr_pulses++;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_din;
      if (in_win(bus.mem_addr)) mem[(bus.mem_addr - BASE) >> 2] = bus.mem_din;
    end
    bus.mem_dout <= in_win(bus.mem_addr) ? mem[(bus.mem_addr - BASE) >> 2] : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned a, n;
    a = addr;
    if (size == 2'b11) return 1'b1;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (a % n != 0) return 1'b1;
    return (a < 64'h1000) || (a + n > 64'h1068);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (size == 2'b10) return w;
    if (size == 2'b00) begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (w >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wd);
    int unsigned off;
    logic [31:0] mask;
    if (size == 2'b10) return wd;
    off  = addr % 4;
    mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int unsigned hold,
                       output logic [31:0] got);
    bit          exp_err, same;
    logic [31:0] exp_rdata;
    int unsigned exp_lat, exp_wr, wr0, edges, idx;

    exp_err   = model_err(size, addr);
    exp_rdata = '0;
    exp_wr    = 0;
    idx       = 0;
    if (exp_err) exp_lat = 0;
    else begin
      idx = (addr - BASE) >> 2;
      if (!we) begin
        exp_lat   = 2;
        exp_rdata = model_load(ref_mem[idx], addr, size, uns);
      end else begin
        exp_wr       = 1;
        exp_lat      = (size == 2'b10) ? 1 : 3;
        ref_mem[idx] = model_store(ref_mem[idx], addr, size, wdata);
      end
    end

    @(negedge clk);
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    wr0 = wr_pulses;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;

    edges = 0;
    while (bus.resp_valid !== 1'b1 && edges < 8) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " resp"}, {29'd0, bus.req_ready, bus.resp_err, bus.resp_rdata},
          {29'd0, 1'b0, exp_err, exp_rdata});
    got = bus.resp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {28'd0, bus.resp_valid, bus.req_ready, bus.resp_err, bus.resp_rdata},
            {28'd0, 1'b1, 1'b0, exp_err, exp_rdata});
    end

    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " release"}, {62'd0, bus.resp_valid, bus.req_ready}, {62'd0, 1'b0, 1'b1});
    check({tag, " write count"}, 64'(wr_pulses - wr0), 64'(exp_wr));
    if (exp_wr != 0)
      check({tag, " write"}, {last_wr_addr, last_wr_data}, {addr & 32'hFFFF_FFFC, ref_mem[idx]});
    same = 1'b1;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) same = 1'b0;
    check({tag, " memory"}, 64'(same), 64'd1);
  endtask

  initial begin
    logic [31:0] got;
    int unsigned wr0;
    bit          quiet;
    logic        rwe, runs;
    logic [1:0]  rsz;

    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    reset = 1'b0;
    preload = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    check("reset outputs",
          {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr_en, bus.resp_rdata, 28'd0},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 28'd0});
    check("reset mem bus", {bus.mem_addr, bus.mem_din}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("SW 1004", 1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, 0, got);
    do_op("LW 1004", 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0, got);
    check("LW 1004 value", 64'(got), 64'hDEADBEEF);
    do_op("SB 1005", 1'b1, 2'b00, 1'b0, 32'h1005, 32'h0000_00AA, 0, got);
    check("SB 1005 word", 64'(mem[1]), 64'hDEADAAEF);
    do_op("LB 1005", 1'b0, 2'b00, 1'b0, 32'h1005, 32'h0, 0, got);
    check("LB 1005 value", 64'(got), 64'hFFFFFFAA);
    do_op("LBU 1005", 1'b0, 2'b00, 1'b1, 32'h1005, 32'h0, 0, got);
    check("LBU 1005 value", 64'(got), 64'h000000AA);
    do_op("LH 1006", 1'b0, 2'b01, 1'b0, 32'h1006, 32'h0, 0, got);
    check("LH 1006 value", 64'(got), 64'hFFFFDEAD);
    do_op("LHU 1006", 1'b0, 2'b01, 1'b1, 32'h1006, 32'h0, 0, got);
    check("LHU 1006 value", 64'(got), 64'h0000DEAD);
    do_op("SH 1004", 1'b1, 2'b01, 1'b0, 32'h1004, 32'h0000_1234, 0, got);
    check("SH 1004 word", 64'(mem[1]), 64'hDEAD1234);

    do_op("err LW 1002", 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 0, got);
    do_op("err SH 1005", 1'b1, 2'b01, 1'b0, 32'h1005, 32'h5555, 0, got);
    do_op("err SW 0FFC", 1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h1111_2222, 0, got);
    do_op("err LW 1068", 1'b0, 2'b10, 1'b0, 32'h1068, 32'h0, 0, got);
    do_op("err size11", 1'b1, 2'b11, 1'b0, 32'h1008, 32'h3333_4444, 0, got);
    do_op("LW last word", 1'b0, 2'b10, 1'b0, 32'h1064, 32'h0, 0, got);
    do_op("err LH 1067", 1'b0, 2'b01, 1'b0, 32'h1066 + 32'h1, 32'h0, 0, got);

    do_op("backpressure LW", 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 5, got);

    // Reset while the read half of a byte store is in flight.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_addr = 32'h1005; bus.req_wdata = 32'h77;
    wr0 = wr_pulses;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("midreset RD bus", {31'd0, bus.mem_wr_en, bus.mem_addr}, {31'd0, 1'b0, 32'h1004});
    #2 reset = 1'b0;
    #1;
    check("midreset outputs",
          {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr_en, bus.resp_rdata, 28'd0},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 28'd0});
    check("midreset mem bus", {bus.mem_addr, bus.mem_din}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) quiet = 1'b0;
    end
    check("midreset no response", 64'(quiet), 64'd1);
    check("midreset no write", 64'(wr_pulses - wr0), 64'd0);
    do_op("LW after reset", 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0, got);
    check("LW after reset value", 64'(got), 64'hDEAD1234);

    for (int n = 0; n < 60; n++) begin
      rwe  = 1'($urandom);
      rsz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      runs = 1'($urandom);
      do_op("random", rwe, rsz, runs, 32'h0FF8 + $urandom_range(0, 32'h78), $urandom,
            $urandom_range(0, 2), got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
